k_band_energy_acc: RTL and testbench
====================================

// Module: k_band_energy_acc
// PURPOSE
//  Successor to k_energy_computer: per-bin energy re^2+im^2 of complex FFT output, summed over
//  contiguous bands of BINS_PER_BAND bins; emits one band energy per band on an AXI-stream master.
//  Sits between the FFT output stream and the compressor gain logic. Adds framing, band index,
//  backpressure and frame-error detection.
// PARAMETERS
//  IN_WIDTH       16  signed width of each re/im component
//  OUT_WIDTH      48  band energy width (unsigned); >= 2*IN_WIDTH+1+log2(BINS_PER_BAND) unless K_BAND_SAT_EN
//  NUM_BINS       16  FFT points per frame; multiple of BINS_PER_BAND
//  BINS_PER_BAND  4   bins summed per band; power of 2, >= 1
//  BAND_IDX_W     2   width of band index = clog2(NUM_BINS/BINS_PER_BAND), min 1
// PORTS
//  clk            in   1             rising-edge clock
//  aresetn        in   1             synchronous reset, active low
//  s_axis_tdata   in   2*IN_WIDTH    {re[2*IN_WIDTH-1:IN_WIDTH], im[IN_WIDTH-1:0]}, two's complement
//  s_axis_tvalid  in   1             input beat valid
//  s_axis_tready  out  1             input beat accepted when tvalid&tready
//  s_axis_tlast   in   1             marks bin NUM_BINS-1 of a frame
//  m_axis_tdata   out  OUT_WIDTH     band energy
//  m_axis_tuser   out  BAND_IDX_W    band index within frame
//  m_axis_tlast   out  1             last band of frame
//  m_axis_tvalid  out  1             output beat valid
//  m_axis_tready  in   1             downstream accept
//  frame_err      out  1             one-cycle pulse on tlast/bin-count mismatch
// BEHAVIOUR
//  Reset (aresetn=0 at clk edge): all outputs 0, bin counter, accumulator, pipeline valids cleared;
//   s_axis_tready=0 while aresetn=0. Reset mid-band discards partial sum; next band starts fresh.
//  Global stall: adv = ~m_axis_tvalid | m_axis_tready; s_axis_tready = aresetn & adv.
//   When adv=0 every stage holds; m_axis_* stable until accepted (AXI rule).
//  Pipeline (each stage has a valid bit, advances on adv, bubbles pass through):
//   S1 register re, im, bin flags; S2 re*re, im*im (signed, 2*IN_WIDTH bits each);
//   S3 e = re^2+im^2 (2*IN_WIDTH+1 bits, unsigned, zero-extended); accumulate acc += e.
//   On the bin closing a band, acc+e loads output register, m_axis_tvalid=1, acc cleared same edge.
//   Latency: closing beat accepted at edge N -> m_axis_tvalid high after edge N+3 (no stall).
//   Throughput 1 bin/cycle; back-to-back bands need no idle cycle.
//  -32768 components: square = 2^30, pair sum 2^31, exact; no truncation anywhere.
//  Bin counter 0..NUM_BINS-1, increments per accepted beat; band = bin/BINS_PER_BAND;
//   band closes at bin%BINS_PER_BAND==BINS_PER_BAND-1 or on any accepted tlast.
//  m_axis_tlast=1 on the band closing bin NUM_BINS-1 or an accepted tlast.
//  Early tlast (bin<NUM_BINS-1): partial band emitted (tlast=1, tuser=current band), counter->0,
//   frame_err pulses 1 cycle at edge N+1.
//  Missing tlast at bin NUM_BINS-1: frame by count (tlast=1 output), counter wraps to 0, frame_err pulse.
//  Without K_BAND_SAT_EN accumulation is modulo 2^OUT_WIDTH (cannot overflow if width rule met).
// CONFIGURATION
//  K_BAND_SAT_EN defined: OUT_WIDTH may be below the rule; acc saturates at 2^OUT_WIDTH-1 and
//   stays there until the band closes; output carries the saturated value.
//  K_BAND_SAT_EN undefined: no compare logic; width rule mandatory; modulo wrap.
// TESTING (NUM_BINS=16, BINS_PER_BAND=4, OUT_WIDTH=48 unless noted)
//  1 4 beats re=0x0003 im=0x0004, tready=1 -> tdata=100, tuser=0, tlast=0, valid 3 cycles after beat 4.
//  2 16 beats re=im=0x8000, tlast on 16th -> 4 beats tdata=0x2_0000_0000, tuser 0..3, tlast only on tuser=3.
//  3 random valid gaps + m_axis_tready=0 for 10 cycles -> s_axis_tready=0, m_axis_* stable, no bin lost/duplicated vs model.
//  4 tlast on bin 5 (re=1,im=0 all) -> band0=4, band1=2 with tlast=1, frame_err 1 pulse, next frame tuser=0.
//  5 aresetn=0 for 1 cycle after 2 beats of re=0x0010 -> all outputs 0; next 4 beats re=1 give tdata=4, tuser=0.
//  6 K_BAND_SAT_EN, OUT_WIDTH=32: 4 beats re=im=0x8000 -> tdata=0xFFFFFFFF; without macro OUT_WIDTH>=35 required.

Source files
------------

// File: rtl/k_band_energy_acc.sv
// Band energy accumulator: sums re^2+im^2 over BINS_PER_BAND bins of an FFT frame and
// emits one AXI-stream beat per band. Optional saturation enabled by defining K_BAND_SAT_EN.
`timescale 1ns/1ps

module k_band_energy_acc #(
  parameter int IN_WIDTH      = 16,
  parameter int OUT_WIDTH     = 48,
  parameter int NUM_BINS      = 16,
  parameter int BINS_PER_BAND = 4,
  parameter int BAND_IDX_W    = 2
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [2*IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [OUT_WIDTH-1:0]    m_axis_tdata,
  output logic [BAND_IDX_W-1:0]   m_axis_tuser,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    frame_err
);

  localparam int EW      = 2*IN_WIDTH + 1;
  localparam int CW      = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int LOG_BPB = $clog2(BINS_PER_BAND);
  localparam logic [CW-1:0] BIN_LAST  = CW'(NUM_BINS - 1);
  localparam logic [CW-1:0] BAND_MASK = CW'(BINS_PER_BAND - 1);

  // Handshake: a beat moves on a rising edge when valid & ready; the whole pipeline
  // advances together whenever the output register is empty or being accepted.
  logic adv;
  logic accept;
  logic [CW-1:0] bin;
  logic in_last_bin;
  logic in_close;
  logic in_last;
  logic in_err;

  logic                          s1_v;
  logic signed [IN_WIDTH-1:0]    s1_re;
  logic signed [IN_WIDTH-1:0]    s1_im;
  logic                          s1_close;
  logic                          s1_last;
  logic                          s1_err;
  logic [BAND_IDX_W-1:0]         s1_band;

  logic                          s2_v;
  logic signed [2*IN_WIDTH-1:0]  s2_sq_re;
  logic signed [2*IN_WIDTH-1:0]  s2_sq_im;
  logic                          s2_close;
  logic                          s2_last;
  logic [BAND_IDX_W-1:0]         s2_band;

  logic                          s3_v;
  logic [EW-1:0]                 s3_e;
  logic                          s3_close;
  logic                          s3_last;
  logic [BAND_IDX_W-1:0]         s3_band;

  logic [OUT_WIDTH-1:0]          acc;
  logic [OUT_WIDTH-1:0]          acc_next;

  assign adv           = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = aresetn & adv;
  assign accept        = s_axis_tvalid & s_axis_tready;

  // A frame ends either by tlast or by count; disagreement between the two is an error.
  assign in_last_bin = (bin == BIN_LAST);
  assign in_close    = s_axis_tlast | ((bin & BAND_MASK) == BAND_MASK);
  assign in_last     = s_axis_tlast | in_last_bin;
  assign in_err      = s_axis_tlast ^ in_last_bin;

`ifdef K_BAND_SAT_EN
  localparam int SW = ((OUT_WIDTH > EW) ? OUT_WIDTH : EW) + 1;
  logic [SW-1:0] sum_wide;

  always_comb begin
    sum_wide = SW'(acc) + SW'(s3_e);
    acc_next = sum_wide[OUT_WIDTH-1:0];
    if (sum_wide[SW-1:OUT_WIDTH] != '0) begin
      acc_next = '1;
    end
  end
`else
  assign acc_next = acc + OUT_WIDTH'(s3_e);
`endif

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      bin           <= '0;
      s1_v          <= 1'b0;
      s1_re         <= '0;
      s1_im         <= '0;
      s1_close      <= 1'b0;
      s1_last       <= 1'b0;
      s1_err        <= 1'b0;
      s1_band       <= '0;
      s2_v          <= 1'b0;
      s2_sq_re      <= '0;
      s2_sq_im      <= '0;
      s2_close      <= 1'b0;
      s2_last       <= 1'b0;
      s2_band       <= '0;
      s3_v          <= 1'b0;
      s3_e          <= '0;
      s3_close      <= 1'b0;
      s3_last       <= 1'b0;
      s3_band       <= '0;
      acc           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      frame_err <= adv & s1_v & s1_err;
      if (accept) begin
        bin <= in_last ? '0 : bin + CW'(1);
      end
      if (adv) begin
        s1_v     <= accept;
        s1_re    <= s_axis_tdata[2*IN_WIDTH-1:IN_WIDTH];
        s1_im    <= s_axis_tdata[IN_WIDTH-1:0];
        s1_close <= in_close;
        s1_last  <= in_last;
        s1_err   <= in_err;
        s1_band  <= BAND_IDX_W'(bin >> LOG_BPB);

        s2_v     <= s1_v;
        s2_sq_re <= (2*IN_WIDTH)'(s1_re) * (2*IN_WIDTH)'(s1_re);
        s2_sq_im <= (2*IN_WIDTH)'(s1_im) * (2*IN_WIDTH)'(s1_im);
        s2_close <= s1_close;
        s2_last  <= s1_last;
        s2_band  <= s1_band;

        // Squares are never negative, so zero-extension gives the exact unsigned sum.
        s3_v     <= s2_v;
        s3_e     <= {1'b0, s2_sq_re} + {1'b0, s2_sq_im};
        s3_close <= s2_close;
        s3_last  <= s2_last;
        s3_band  <= s2_band;

        if (s3_v) begin
          acc <= s3_close ? '0 : acc_next;
        end
        m_axis_tvalid <= s3_v & s3_close;
        if (s3_v & s3_close) begin
          m_axis_tdata <= acc_next;
          m_axis_tuser <= s3_band;
          m_axis_tlast <= s3_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_k_band_energy_acc.sv
// Bench for k_band_energy_acc: directed and randomized frames against a band-sum model,
// with an expected-beat queue drained by an output monitor. Define K_BAND_SAT_EN for the 32-bit saturating build.
`timescale 1ns/1ps

module tb_k_band_energy_acc;

  localparam int IW  = 16;
  localparam int NB  = 16;
  localparam int BPB = 4;
  localparam int BW  = 2;
`ifdef K_BAND_SAT_EN
  localparam int OW  = 32;
  localparam bit SAT = 1'b1;
`else
  localparam int OW  = 48;
  localparam bit SAT = 1'b0;
`endif
  localparam int EXPW = OW + BW + 1;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic [2*IW-1:0]   s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic              s_axis_tlast = 1'b0;
  logic [OW-1:0]     m_axis_tdata;
  logic [BW-1:0]     m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              frame_err;

  k_band_energy_acc #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM_BINS(NB), .BINS_PER_BAND(BPB), .BAND_IDX_W(BW)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .frame_err(frame_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EXPW-1:0] exp_q[$];

  int      m_bin = 0;
  longint  m_sum = 0;
  int      exp_err = 0;
  int      seen_err = 0;
  int      n_out = 0;
  int      rdy_mode = 0;
  longint unsigned last_data = 0;
  int      last_user = 0;
  int      last_last = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a band is the plain sum of per-bin energies; frames end at tlast or bin NB-1.
  task automatic model_beat(input int re, input int im, input bit last);
    longint e;
    longint maxv;
    bit at_end;
    bit closes;
    logic [EXPW-1:0] v;
    maxv = (longint'(1) << OW) - 1;
    e = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    if (SAT && (m_sum + e > maxv)) m_sum = maxv;
    else m_sum = m_sum + e;
    at_end = (m_bin == NB - 1);
    closes = last || ((m_bin % BPB) == BPB - 1);
    if (last != at_end) exp_err++;
    if (closes) begin
      v = {OW'(m_sum), BW'(m_bin / BPB), (last || at_end)};
      exp_q.push_back(v);
      m_sum = 0;
    end
    m_bin = (last || at_end) ? 0 : m_bin + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input int re, input int im, input bit last);
    bit done;
    int k;
    done = 1'b0;
    k = 0;
    s_axis_tdata  = {re[15:0], im[15:0]};
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!done && k < 200) begin
      @(negedge clk);
      done = s_axis_tready;
      if (done) model_beat(re, im, last);
      @(posedge clk);
      #1;
      k++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got tready=0 for %0d cycles expected accept", k);
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_m_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, 0);
    check("rst_frame_err", frame_err, 0);
    aresetn = 1'b1;
    m_bin = 0;
    m_sum = 0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- downstream ready ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit prev_stall;
    logic [EXPW-1:0] prev_beat;
    logic [EXPW-1:0] act;
    logic [EXPW-1:0] exp;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (aresetn) begin
        act = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        if (frame_err) seen_err++;
        if (prev_stall) begin
          check("hold_valid", m_axis_tvalid, 1);
          check("hold_beat", act, prev_beat);
        end
        prev_stall = 1'b0;
        if (m_axis_tvalid) begin
          if (!m_axis_tready) begin
            check("stall_s_tready", s_axis_tready, 0);
            prev_stall = 1'b1;
            prev_beat  = act;
          end else if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got 0x%0h expected none", act);
          end else begin
            exp = exp_q.pop_front();
            check("band_out", act, exp);
            last_data = m_axis_tdata;
            last_user = m_axis_tuser;
            last_last = m_axis_tlast;
            n_out++;
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int outs0;
    int err0;
    do_reset();

    // 3^2+4^2 per bin, four bins; also pin down the 3-edge latency.
    for (int i = 0; i < 4; i++) send_beat(3, 4, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lat_n2_valid", m_axis_tvalid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_n3_valid", m_axis_tvalid, 1);
    @(posedge clk);
    #1;
    drain();
    check("t1_data", last_data, 100);
    check("t1_user", last_user, 0);
    check("t1_last", last_last, 0);

    // Full frame of most-negative components.
    do_reset();
    outs0 = n_out;
    for (int i = 0; i < NB; i++) send_beat(-32768, -32768, i == NB - 1);
    drain();
    check("t2_beats", n_out - outs0, 4);
`ifndef K_BAND_SAT_EN
    check("t2_data", last_data, 64'h2_0000_0000);
`endif
    check("t2_user", last_user, 3);
    check("t2_last", last_last, 1);

    // Early tlast on bin 5, then a fresh frame.
    do_reset();
    err0 = seen_err;
    for (int i = 0; i < 6; i++) send_beat(1, 0, i == 5);
    drain();
    check("t4_err_pulse", seen_err - err0, 1);
    check("t4_band1_data", last_data, 2);
    check("t4_band1_last", last_last, 1);
    for (int i = 0; i < 4; i++) send_beat(1, 0, 1'b0);
    drain();
    check("t4_next_user", last_user, 0);
    check("t4_next_data", last_data, 4);

    // Reset in the middle of a band discards the partial sum.
    do_reset();
    send_beat(16, 0, 1'b0);
    send_beat(16, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(1, 0, 1'b0);
    drain();
    check("t5_data", last_data, 4);
    check("t5_user", last_user, 0);

    // Random traffic with gaps, random backpressure and one forced 10-cycle stall.
    do_reset();
    rdy_mode = 1;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          int re;
          int im;
          bit last;
          re = int'($urandom_range(0, 65535)) - 32768;
          im = int'($urandom_range(0, 65535)) - 32768;
          if (m_bin == NB - 1) last = ($urandom_range(0, 7) != 0);
          else last = ($urandom_range(0, 19) == 0);
          send_beat(re, im, last);
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
      end
      begin
        repeat (30) @(posedge clk);
        #1;
        rdy_mode = 2;
        repeat (10) @(posedge clk);
        #1;
        rdy_mode = 1;
      end
    join
    drain();
    rdy_mode = 0;

`ifdef K_BAND_SAT_EN
    do_reset();
    for (int i = 0; i < 4; i++) send_beat(-32768, -32768, 1'b0);
    drain();
    check("t6_saturated", last_data, 64'hFFFF_FFFF);
`endif

    idle(5);
    check("frame_err_count", seen_err, exp_err);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
